// File: rtl/player_pkg.sv
// Shared types and arithmetic helpers for the Space Invaders player controller.
package player_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_DYING = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Saturating add: the sum never exceeds max and never wraps.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max}) begin
            return max;
        end else begin
            return s[31:0];
        end
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Control pulses in, ship/bullet/score/state out, between the player controller and its neighbours.
interface player_ctrl_if #(
    parameter int X_W         = 5,
    parameter int Y_W         = 4,
    parameter int NUM_BULLETS = 2,
    parameter int SCORE_W     = 8
);
    logic                         tick;
    logic                         left;
    logic                         right;
    logic                         shoot;
    logic [NUM_BULLETS-1:0]       hit;
    logic                         ship_hit;
    logic                         new_game;
    logic [X_W-1:0]               ship_x;
    logic [NUM_BULLETS*X_W-1:0]   bullet_x;
    logic [NUM_BULLETS*Y_W-1:0]   bullet_y;
    logic [NUM_BULLETS-1:0]       bullet_flying;
    logic [SCORE_W-1:0]           score;
    logic [2:0]                   lives;
    logic [1:0]                   state;

    modport slave (
        input  tick, left, right, shoot, hit, ship_hit, new_game,
        output ship_x, bullet_x, bullet_y, bullet_flying, score, lives, state
    );

    modport master (
        output tick, left, right, shoot, hit, ship_hit, new_game,
        input  ship_x, bullet_x, bullet_y, bullet_flying, score, lives, state
    );
endinterface

// File: rtl/player_ctrl_bullet_slot.sv
// One bullet slot: launches at the top row, falls one row per tick, retires at row 0 or on a hit.
module bullet_slot #(
    parameter int X_W = 5,
    parameter int Y_W = 4
) (
    input  logic           clk_36MHz,
    input  logic           reset,
    input  logic           launch,
    input  logic [X_W-1:0] launch_x,
    input  logic           tick,
    input  logic           hit,
    input  logic           clear,
    output logic           flying,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           valid_hit,
    output logic           idle
);
    localparam logic [Y_W-1:0] Y_TOP = Y_W'((1 << Y_W) - 1);

    logic           flying_r;
    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;

    // A launch into this slot in the same cycle takes precedence over a stray hit.
    assign valid_hit = hit & flying_r & ~launch;
    assign idle      = ~flying_r;

    // Slot state: clear beats launch, launch beats hit, hit beats tick.
    always_ff @(posedge clk_36MHz) begin
        if (!reset) begin
            flying_r <= 1'b0;
            x_r      <= {X_W{1'b0}};
            y_r      <= {Y_W{1'b0}};
        end else if (clear) begin
            flying_r <= 1'b0;
            x_r      <= {X_W{1'b0}};
            y_r      <= {Y_W{1'b0}};
        end else if (launch) begin
            flying_r <= 1'b1;
            x_r      <= launch_x;
            y_r      <= Y_TOP;
        end else if (valid_hit) begin
            flying_r <= 1'b0;
        end else if (tick && flying_r) begin
            if (y_r != {Y_W{1'b0}}) begin
                y_r <= y_r - Y_W'(1);
            end else begin
                flying_r <= 1'b0;
            end
        end else begin
            flying_r <= flying_r;
        end
    end

    assign flying = flying_r;
    assign x      = x_r;
    assign y      = y_r;

endmodule

// File: rtl/player_ctrl.sv
// Player controller: ship movement, bullet pool with fire cooldown, saturating score, lives FSM.
module player_ctrl
    import player_pkg::*;
#(
    parameter int X_W           = 5,
    parameter int Y_W           = 4,
    parameter int NUM_BULLETS   = 2,
    parameter int SCORE_W       = 8,
    parameter int LIVES         = 3,
    parameter int COOLDOWN      = 2,
    parameter int RESPAWN_TICKS = 8
) (
    input  logic          clk_36MHz,
    input  logic          reset,
    player_ctrl_if.slave  bus
);
    localparam int X_MAX     = (1 << X_W) - 1;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;
    localparam int CD_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int RESP_W    = (RESPAWN_TICKS > 0) ? $clog2(RESPAWN_TICKS + 1) : 1;
    localparam logic [X_W-1:0] X_CENTRE = X_W'(X_MAX / 2);

    state_t             state_r, state_s;
    logic [X_W-1:0]     ship_x_r, ship_x_s;
    logic [CD_W-1:0]    cooldown_r, cooldown_s;
    logic [RESP_W-1:0]  resp_r, resp_s;
    logic [SCORE_W-1:0] score_r, score_s;
    logic [2:0]         lives_r, lives_s;

    logic [NUM_BULLETS-1:0] idle_s, valid_hit_s, launch_vec_s, hit_play_s;
    logic                   launch_ok_s, clear_s, taken_s;

    assign hit_play_s  = (state_r == ST_PLAY) ? bus.hit : {NUM_BULLETS{1'b0}};
    assign launch_ok_s = (state_r == ST_PLAY) & bus.shoot & (cooldown_r == CD_W'(0)) & (|idle_s);
    assign clear_s     = ((state_r == ST_PLAY) & bus.ship_hit) | ((state_r == ST_OVER) & bus.new_game);

    // Lowest-index idle slot receives the launch.
    always_comb begin
        taken_s      = 1'b0;
        launch_vec_s = {NUM_BULLETS{1'b0}};
        for (int i = 0; i < NUM_BULLETS; i++) begin
            launch_vec_s[i] = launch_ok_s & idle_s[i] & ~taken_s;
            taken_s         = taken_s | idle_s[i];
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(.X_W(X_W), .Y_W(Y_W)) u_slot (
            .clk_36MHz (clk_36MHz),
            .reset     (reset),
            .launch    (launch_vec_s[g]),
            .launch_x  (ship_x_r),
            .tick      (bus.tick),
            .hit       (hit_play_s[g]),
            .clear     (clear_s),
            .flying    (bus.bullet_flying[g]),
            .x         (bus.bullet_x[g*X_W +: X_W]),
            .y         (bus.bullet_y[g*Y_W +: Y_W]),
            .valid_hit (valid_hit_s[g]),
            .idle      (idle_s[g])
        );
    end

    // Next-state logic for the FSM and all per-game registers.
    always_comb begin
        state_s    = state_r;
        ship_x_s   = ship_x_r;
        cooldown_s = cooldown_r;
        resp_s     = resp_r;
        score_s    = score_r;
        lives_s    = lives_r;
        case (state_r)
            ST_PLAY: begin
                if (bus.left && !bus.right && ship_x_r != X_W'(0)) begin
                    ship_x_s = ship_x_r - X_W'(1);
                end else if (bus.right && !bus.left && ship_x_r != X_W'(X_MAX)) begin
                    ship_x_s = ship_x_r + X_W'(1);
                end else begin
                    ship_x_s = ship_x_r;
                end
                if (launch_ok_s) begin
                    cooldown_s = CD_W'(COOLDOWN);
                end else if (bus.tick && cooldown_r != CD_W'(0)) begin
                    cooldown_s = cooldown_r - CD_W'(1);
                end else begin
                    cooldown_s = cooldown_r;
                end
                score_s = SCORE_W'(sat_add(32'(score_r), 32'(popcount(8'(valid_hit_s))),
                                           32'(SCORE_MAX)));
                if (bus.ship_hit) begin
                    state_s = ST_DYING;
                    lives_s = (lives_r != 3'd0) ? lives_r - 3'd1 : 3'd0;
                    resp_s  = RESP_W'(RESPAWN_TICKS);
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (resp_r == RESP_W'(0)) begin
                    if (lives_r != 3'd0) begin
                        state_s    = ST_PLAY;
                        ship_x_s   = X_CENTRE;
                        cooldown_s = CD_W'(0);
                    end else begin
                        state_s = ST_OVER;
                    end
                end else if (bus.tick) begin
                    resp_s = resp_r - RESP_W'(1);
                end else begin
                    resp_s = resp_r;
                end
            end
            ST_OVER: begin
                if (bus.new_game) begin
                    state_s    = ST_PLAY;
                    score_s    = {SCORE_W{1'b0}};
                    lives_s    = 3'(LIVES);
                    ship_x_s   = X_CENTRE;
                    cooldown_s = CD_W'(0);
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_PLAY;
            end
        endcase
    end

    // State and per-game registers.
    always_ff @(posedge clk_36MHz) begin
        if (!reset) begin
            state_r    <= ST_PLAY;
            ship_x_r   <= X_CENTRE;
            cooldown_r <= CD_W'(0);
            resp_r     <= RESP_W'(0);
            score_r    <= {SCORE_W{1'b0}};
            lives_r    <= 3'(LIVES);
        end else begin
            state_r    <= state_s;
            ship_x_r   <= ship_x_s;
            cooldown_r <= cooldown_s;
            resp_r     <= resp_s;
            score_r    <= score_s;
            lives_r    <= lives_s;
        end
    end

    assign bus.ship_x = ship_x_r;
    assign bus.score  = score_r;
    assign bus.lives  = lives_r;
    assign bus.state  = state_r;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl at default parameters.
module tb_player_ctrl;
    logic clk_36MHz = 1'b0;
    logic reset     = 1'b0;
    int   errors    = 0;
    int   checks    = 0;

    player_ctrl_if bus ();

    player_ctrl dut (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_36MHz = ~clk_36MHz;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_36MHz);
        #1;
    endtask

    task automatic step(input logic t, input logic l, input logic r, input logic s,
                        input logic [1:0] h, input logic sh, input logic ng);
        bus.tick = t; bus.left = l; bus.right = r; bus.shoot = s;
        bus.hit = h; bus.ship_hit = sh; bus.new_game = ng;
        cycle();
        bus.tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.shoot = 1'b0;
        bus.hit = 2'b00; bus.ship_hit = 1'b0; bus.new_game = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic shoot();
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] bx(input int i);
        return 32'(bus.bullet_x[i*5 +: 5]);
    endfunction

    function automatic logic [31:0] by(input int i);
        return 32'(bus.bullet_y[i*4 +: 4]);
    endfunction

    initial begin
        bus.tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.shoot = 1'b0;
        bus.hit = 2'b00; bus.ship_hit = 1'b0; bus.new_game = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_ship", 32'(bus.ship_x), 32'd15);
        check("rst_flying", 32'(bus.bullet_flying), 32'd0);
        check("rst_bx", 32'(bus.bullet_x), 32'd0);
        check("rst_by", 32'(bus.bullet_y), 32'd0);
        check("rst_score", 32'(bus.score), 32'd0);
        check("rst_lives", 32'(bus.lives), 32'd3);

        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            check("right_clamp", 32'(bus.ship_x), (15 + k > 31) ? 32'd31 : 32'(15 + k));
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        check("left_right_both", 32'(bus.ship_x), 32'd31);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check("left_clamp", 32'(bus.ship_x), 32'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        check("ship_at_10", 32'(bus.ship_x), 32'd10);

        shoot();
        check("launch0_fly", 32'(bus.bullet_flying), 32'd1);
        check("launch0_x", bx(0), 32'd10);
        check("launch0_y", by(0), 32'd15);
        shoot();
        check("drop_cooldown", 32'(bus.bullet_flying), 32'd1);
        ticks(1);
        check("fall_y14", by(0), 32'd14);
        shoot();
        check("drop_cooldown1", 32'(bus.bullet_flying), 32'd1);
        ticks(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        shoot();
        check("launch1_fly", 32'(bus.bullet_flying), 32'd3);
        check("launch1_x", bx(1), 32'd11);
        check("launch1_y", by(1), 32'd15);
        ticks(2);
        check("two_fall_y0", by(0), 32'd11);
        check("two_fall_y1", by(1), 32'd13);
        shoot();
        check("drop_full", 32'(bus.bullet_flying), 32'd3);

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        check("hit_tick_fly", 32'(bus.bullet_flying), 32'd1);
        check("hit_tick_score", 32'(bus.score), 32'd1);
        check("hit_tick_y0", by(0), 32'd10);
        for (int k = 1; k <= 10; k++) begin
            ticks(1);
            check("descend", by(0), 32'(10 - k));
        end
        ticks(1);
        check("retire", 32'(bus.bullet_flying), 32'd0);

        shoot();
        check("relaunch_y", by(0), 32'd15);
        for (int k = 1; k <= 16; k++) begin
            ticks(1);
            if (k < 16) begin
                check("flight_y", by(0), 32'(15 - k));
                check("flight_fly", 32'(bus.bullet_flying), 32'd1);
            end else begin
                check("flight_retire16", 32'(bus.bullet_flying), 32'd0);
            end
        end

        for (int k = 0; k < 253; k++) begin
            shoot();
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
            ticks(1);
        end
        check("score_254", 32'(bus.score), 32'd254);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        check("launch_beats_hit_fly", 32'(bus.bullet_flying), 32'd1);
        check("launch_beats_hit_score", 32'(bus.score), 32'd254);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        check("hit_idle_ignored", 32'(bus.score), 32'd254);
        ticks(2);
        shoot();
        check("both_flying", 32'(bus.bullet_flying), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        check("sat_255", 32'(bus.score), 32'd255);
        check("double_hit_clear", 32'(bus.bullet_flying), 32'd0);
        ticks(2);
        shoot();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        check("sat_hold", 32'(bus.score), 32'd255);

        ticks(2);
        shoot();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("die1_state", 32'(bus.state), 32'd1);
        check("die1_lives", 32'(bus.lives), 32'd2);
        check("die1_clear", 32'(bus.bullet_flying), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check("dying_no_move", 32'(bus.ship_x), 32'd11);
        shoot();
        check("dying_no_shoot", 32'(bus.bullet_flying), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("dying_shiphit_ign", 32'(bus.lives), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("dying_newgame_ign", 32'(bus.state), 32'd1);
        ticks(8);
        check("dying_after_8", 32'(bus.state), 32'd1);
        cycle();
        check("respawn_state", 32'(bus.state), 32'd0);
        check("respawn_centre", 32'(bus.ship_x), 32'd15);

        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("die2_lives", 32'(bus.lives), 32'd1);
        ticks(8);
        cycle();
        check("respawn2_state", 32'(bus.state), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("die3_lives", 32'(bus.lives), 32'd0);
        ticks(8);
        cycle();
        check("over_state", 32'(bus.state), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        check("over_no_move", 32'(bus.ship_x), 32'd15);
        shoot();
        check("over_no_shoot", 32'(bus.bullet_flying), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("over_shiphit_ign", 32'(bus.state), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("newgame_state", 32'(bus.state), 32'd0);
        check("newgame_lives", 32'(bus.lives), 32'd3);
        check("newgame_score", 32'(bus.score), 32'd0);
        check("newgame_ship", 32'(bus.ship_x), 32'd15);

        shoot();
        check("ng_launch", 32'(bus.bullet_flying), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        check("hit_and_die_score", 32'(bus.score), 32'd1);
        check("hit_and_die_state", 32'(bus.state), 32'd1);
        check("hit_and_die_fly", 32'(bus.bullet_flying), 32'd0);

        ticks(1);
        reset = 1'b0;
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        reset = 1'b1;
        check("rst_dying_state", 32'(bus.state), 32'd0);
        check("rst_dying_lives", 32'(bus.lives), 32'd3);
        check("rst_dying_score", 32'(bus.score), 32'd0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        shoot();
        check("pre_rst_x", bx(0), 32'd16);
        ticks(1);
        reset = 1'b0;
        bus.tick = 1'b1; bus.shoot = 1'b1; bus.right = 1'b1;
        cycle();
        bus.tick = 1'b0; bus.shoot = 1'b0; bus.right = 1'b0;
        reset = 1'b1;
        check("rst_flight_fly", 32'(bus.bullet_flying), 32'd0);
        check("rst_flight_bx", 32'(bus.bullet_x), 32'd0);
        check("rst_flight_by", 32'(bus.bullet_y), 32'd0);
        check("rst_flight_ship", 32'(bus.ship_x), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Parametrised player controller for the Space Invaders game core, sitting between the input debouncers and the collision/render logic. It owns one ship, a pool of `NUM_BULLETS` concurrent bullets with a fire cooldown, a saturating multi-hit score, and a lives counter with a play/dying/game-over state machine. All outputs are registered and feed the renderer and collision detector directly.

## Interface
Parameters:
- `X_W`, default 5: ship/bullet column width; `X_MAX` = 2^X_W − 1.
- `Y_W`, default 4: bullet row width; launch row `Y_TOP` = 2^Y_W − 1.
- `NUM_BULLETS`, default 2: concurrent bullet slots, 1..8.
- `SCORE_W`, default 8: score width.
- `LIVES`, default 3: lives at game start, 1..7.
- `COOLDOWN`, default 2: ticks after a launch before the next launch is allowed.
- `RESPAWN_TICKS`, default 8: ticks spent in DYING.

Ports:
- `clk_36MHz`, in, 1: clock.
- `reset`, in, 1: synchronous, active-low.
- `tick`, in, 1: one-cycle game-step strobe.
- `left`, `right`, `shoot`, in, 1 each: one-cycle debounced pulses.
- `hit`, in, NUM_BULLETS: bit i set means bullet i struck an alien.
- `ship_hit`, in, 1: ship struck.
- `new_game`, in, 1: restart request.
- `ship_x`, out, X_W: ship column.
- `bullet_x`, out, NUM_BULLETS·X_W: slot i is in bits [i·X_W +: X_W].
- `bullet_y`, out, NUM_BULLETS·Y_W: packed the same way as `bullet_x`.
- `bullet_flying`, out, NUM_BULLETS: one bit per slot.
- `score`, out, SCORE_W: current score.
- `lives`, out, 3: lives remaining.
- `state`, out, 2: PLAY=0, DYING=1, OVER=2.

## Operation
- Reset values: state=PLAY, ship_x=X_MAX/2 (floor), all bullets idle with x=0 and y=0, score=0, lives=LIVES, cooldown=0, respawn counter=0.
- Ship, PLAY only:
  - `left` moves −1 and `right` moves +1, clamped to 0..X_MAX.
  - `left` and `right` in the same cycle: no move.
  - Moves act on the pulse itself, independent of `tick`.
- Launch:
  - Conditions: PLAY, `shoot`=1, cooldown=0, and at least one idle slot.
  - The lowest-index idle slot becomes flying with x=ship_x and y=Y_TOP.
  - Cooldown loads COOLDOWN.
  - `shoot` that fails any condition is dropped, not queued.
- Flight, on `tick`:
  - A flying bullet with y>0 decrements y.
  - A flying bullet with y=0 retires (flying=0).
  - Cooldown decrements on `tick` while it is nonzero.
- Hit:
  - `hit[i]` on a flying slot clears that slot and counts one point.
  - `hit[i]` on an idle slot is ignored.
  - Hit and `tick` in the same cycle: the hit wins.
  - A launch and a hit on the same slot in the same cycle: the slot launches and the hit is ignored.
- Score:
  - Adds the popcount of the valid hits each cycle.
  - Saturates at 2^SCORE_W − 1, with no wrap.
  - Hits count in PLAY only.
- State machine:
  - PLAY → DYING on `ship_hit`: lives decrements, all bullets are cleared, respawn counter loads RESPAWN_TICKS.
  - DYING: counter decrements on `tick`.
    - At 0 with lives>0: go to PLAY, ship_x recentres, cooldown clears.
    - At 0 with lives=0: go to OVER.
  - OVER → PLAY on `new_game`: score=0, lives=LIVES, ship recentred, bullets idle, cooldown=0.
  - `new_game` in any other state is ignored.
  - `ship_hit` outside PLAY is ignored.
  - In DYING and OVER, `left`, `right`, `shoot` and `hit` are ignored.
- `ship_hit` and `hit` in the same PLAY cycle: hits score first, then the state moves to DYING and bullets clear.

## Timing
- Every output is registered: an input pulse at edge n shows on the outputs after edge n.
- Latency is 1 cycle for every effect: launch, move, hit, score and state.
- `tick` may assert on consecutive cycles; no minimum spacing.
- A bullet launched at y=Y_TOP retires on the (Y_TOP+1)-th tick after launch.
- `reset` low wins over all other inputs in any state, mid-flight included.

## Structure
- Package `player_pkg`:
  - state enum (PLAY, DYING, OVER).
  - Helper function `popcount`.
  - Helper function `sat_add`.
- Sub-module `bullet_slot`, instantiated NUM_BULLETS times:
  - One slot's flying, x and y.
  - Inputs: launch, launch_x, tick, hit, clear.
  - Outputs: valid-hit and idle.
- Top level holds the ship, cooldown, lowest-index free-slot select, score adder, lives and the FSM.

## Test plan
- Reset then 20 `right` pulses (X_W=5) → ship_x goes 15..31, holds at 31; `left` and `right` together → no change.
- `shoot` at ship_x=10 → slot0 flying, x=10, y=15; second `shoot` before 2 ticks → dropped; after 2 ticks `shoot` → slot1 launches; third `shoot` with both slots busy → dropped.
- Slot0 flying, 16 ticks → y steps 15→0 and slot0 retires on tick 16.
- `hit`=2'b11 with both slots flying, score=254, SCORE_W=8 → score=255 and both slots idle; further hits keep score at 255.
- `ship_hit` three times (LIVES=3), each followed by 8 ticks → lives 2, 1, 0, state ends in OVER; `new_game` → PLAY, lives=3, score=0, ship_x=15.
- `reset` low mid-flight in DYING → all outputs return to reset values on the next edge.
